kalman_axis_scheduler: RTL and testbench

//  Time-shares one 2-state kalman_filter_top core among NUM_AXIS measurement streams (X,Y,Z,T).

---
 rtl/kalman_axis_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_kalman_axis_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kalman_axis_scheduler.sv
// Time-shares one 2-state Kalman core among NUM_AXIS measurement streams.
// Per-axis X/P live here; a round-robin arbiter dispatches one update at a time.
module kalman_axis_scheduler #(
  parameter int BIT_NUM     = 18,
  parameter int FRAC_NUM    = 9,
  parameter int NUM_AXIS    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [NUM_AXIS-1:0]      meas_valid,
  output logic [NUM_AXIS-1:0]      meas_ready,
  input  logic [NUM_AXIS*BIT_NUM-1:0] meas_data,
  input  logic                     init_en,
  input  logic [2:0]               init_axis,
  input  logic [2:0]               init_sel,
  input  logic [BIT_NUM-1:0]       init_data,
  output logic                     init_err,
  output logic                     core_enable,
  output logic [BIT_NUM-1:0]       core_Zt,
  output logic [2*BIT_NUM-1:0]     core_X_in,
  output logic [4*BIT_NUM-1:0]     core_P_in,
  input  logic                     core_valid,
  input  logic [2*BIT_NUM-1:0]     core_X_out,
  input  logic [4*BIT_NUM-1:0]     core_P_out,
  output logic                     res_valid,
  output logic [2:0]               res_axis,
  output logic [2*BIT_NUM-1:0]     res_X,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int AW    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
  localparam int CW    = $clog2(TIMEOUT_CYC) + 1;
  localparam int NWORD = 6;  // X00 X10 P00 P01 P10 P11

  // FRAC_NUM is informational only; this empty block keeps it referenced.
  if (FRAC_NUM >= BIT_NUM) begin : g_frac_wider_than_word
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WBACK} state_t;
  typedef logic [BIT_NUM-1:0] word_t;

  state_t state, state_nxt;

  word_t st_q [NUM_AXIS][NWORD];
  word_t disp [NWORD];
  word_t zt_arr [NUM_AXIS];

  logic [AW-1:0]        rr_ptr, cur_axis, grant, cand, init_idx;
  logic                 grant_found, handshake, init_ok, init_bad;
  logic [CW-1:0]        wait_cnt;
  logic [2*BIT_NUM-1:0] x_cap;
  logic [4*BIT_NUM-1:0] p_cap;

  for (genvar i = 0; i < NUM_AXIS; i++) begin : g_zt
    assign zt_arr[i] = meas_data[i*BIT_NUM +: BIT_NUM];
  end

  // Round-robin: first requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_AXIS; k++) begin
      cand = AW'((int'(rr_ptr) + k) % NUM_AXIS);
      if (!grant_found && meas_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  // An in-flight axis belongs to the writeback; init to it is refused.
  always_comb begin
    init_idx = init_axis[AW-1:0];
    init_bad = 1'b0;
    if (init_en) begin
      if (int'(init_axis) >= NUM_AXIS || int'(init_sel) >= NWORD)
        init_bad = 1'b1;
      else if (state != IDLE && init_idx == cur_axis)
        init_bad = 1'b1;
    end
    init_ok = init_en && !init_bad;
  end

  // Dispatch words see a same-cycle init write to the granted axis.
  always_comb begin
    for (int j = 0; j < NWORD; j++) begin
      disp[j] = (init_ok && init_idx == grant && int'(init_sel) == j) ? init_data
                                                                       : st_q[grant][j];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    meas_ready  = '0;
    handshake   = 1'b0;
    core_enable = 1'b0;
    res_valid   = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          meas_ready[grant] = 1'b1;
          handshake         = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        core_enable = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          state_nxt = WBACK;
        end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WBACK: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state != IDLE);
    if (srst) begin
      state_nxt   = IDLE;
      meas_ready  = '0;
      handshake   = 1'b0;
      core_enable = 1'b0;
      res_valid   = 1'b0;
      timeout_err = 1'b0;
      busy        = 1'b0;
    end
  end

  assign init_err = init_bad && !srst;
  assign res_axis = (state == WBACK && !srst) ? 3'(cur_axis) : 3'd0;
  assign res_X    = (state == WBACK && !srst) ? x_cap : '0;

  always_ff @(posedge clk) begin
    if (srst) begin
      // NOTE: the axis register file is reset explicitly; a cleared tracker must read back zero.
      for (int a = 0; a < NUM_AXIS; a++)
        for (int j = 0; j < NWORD; j++)
          st_q[a][j] <= '0;
      rr_ptr    <= '0;
      cur_axis  <= '0;
      wait_cnt  <= '0;
      x_cap     <= '0;
      p_cap     <= '0;
      core_Zt   <= '0;
      core_X_in <= '0;
      core_P_in <= '0;
    end else begin
      if (handshake) begin
        cur_axis  <= grant;
        rr_ptr    <= AW'((int'(grant) + 1) % NUM_AXIS);
        core_Zt   <= zt_arr[grant];
        core_X_in <= {disp[1], disp[0]};
        core_P_in <= {disp[5], disp[4], disp[3], disp[2]};
      end

      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);

      if (state == WAIT && core_valid) begin
        x_cap <= core_X_out;
        p_cap <= core_P_out;
      end

      if (state == WBACK) begin
        st_q[cur_axis][0] <= x_cap[BIT_NUM-1:0];
        st_q[cur_axis][1] <= x_cap[2*BIT_NUM-1:BIT_NUM];
        for (int j = 0; j < 4; j++)
          st_q[cur_axis][2+j] <= p_cap[j*BIT_NUM +: BIT_NUM];
      end

      // Writeback and init never target the same axis: init_bad rejects that case.
      if (init_ok) st_q[init_idx][init_sel] <= init_data;
    end
  end

endmodule

// File: tb/tb_kalman_axis_scheduler.sv
// Directed bench for kalman_axis_scheduler with a fixed-latency stub core.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_kalman_axis_scheduler;

  localparam int BW = 18;
  localparam int NA = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          srst;
  logic [NA-1:0] meas_valid;
  logic [NA-1:0] meas_ready;
  logic [NA*BW-1:0] meas_data;
  logic          init_en;
  logic [2:0]    init_axis, init_sel;
  logic [BW-1:0] init_data;
  logic          init_err, core_enable;
  logic [BW-1:0] core_Zt;
  logic [2*BW-1:0] core_X_in;
  logic [4*BW-1:0] core_P_in;
  logic          core_valid;
  logic [2*BW-1:0] core_X_out;
  logic [4*BW-1:0] core_P_out;
  logic          res_valid;
  logic [2:0]    res_axis;
  logic [2*BW-1:0] res_X;
  logic          timeout_err, busy;

  logic [BW-1:0]   zt_tb [NA];
  logic [2*BW-1:0] mx [NA];
  logic [4*BW-1:0] mp [NA];

  int n_cmp = 0;
  int n_bad = 0;

  assign meas_data = {zt_tb[3], zt_tb[2], zt_tb[1], zt_tb[0]};

  always #5 clk = ~clk;

  kalman_axis_scheduler #(
    .BIT_NUM(BW), .FRAC_NUM(9), .NUM_AXIS(NA), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .srst(srst),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_data(meas_data),
    .init_en(init_en), .init_axis(init_axis), .init_sel(init_sel),
    .init_data(init_data), .init_err(init_err),
    .core_enable(core_enable), .core_Zt(core_Zt), .core_X_in(core_X_in),
    .core_P_in(core_P_in), .core_valid(core_valid), .core_X_out(core_X_out),
    .core_P_out(core_P_out),
    .res_valid(res_valid), .res_axis(res_axis), .res_X(res_X),
    .timeout_err(timeout_err), .busy(busy)
  );

  // Stub core: X00 += Zt, X10 += 7, P00 >>= 1, P01 += 2, P10 += 3, P11 += 4.
  function automatic logic [2*BW-1:0] mdl_x(input logic [2*BW-1:0] x, input logic [BW-1:0] z);
    return {x[2*BW-1:BW] + 18'd7, x[BW-1:0] + z};
  endfunction

  function automatic logic [4*BW-1:0] mdl_p(input logic [4*BW-1:0] p);
    return {p[71:54] + 18'd4, p[53:36] + 18'd3, p[35:18] + 18'd2, {1'b0, p[17:1]}};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int a = 0; a < NA; a++) begin
      mx[a] = '0;
      mp[a] = '0;
    end
  endtask

  task automatic init_write(input logic [2:0] ax, input logic [2:0] sel,
                            input logic [BW-1:0] d, output logic err);
    init_en = 1'b1; init_axis = ax; init_sel = sel; init_data = d;
    #1 err = init_err;
    step();
    init_en = 1'b0;
    #1;
  endtask

  // Entered in the ISSUE cycle; returns in the WBACK cycle.
  task automatic respond(input int lat);
    logic [2*BW-1:0] xi;
    logic [4*BW-1:0] pi;
    logic [BW-1:0]   z;
    xi = core_X_in; pi = core_P_in; z = core_Zt;
    repeat (lat) step();
    core_valid = 1'b1; core_X_out = mdl_x(xi, z); core_P_out = mdl_p(pi);
    step();
    core_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [NA+5+3+2*BW+BW+2*BW+4*BW-1:0] outs;
    for (int r = 0; r < 2; r++) begin
      step();
      #1 outs = {meas_ready, core_enable, res_valid, init_err, timeout_err, busy,
                 res_axis, res_X, core_Zt, core_X_in, core_P_in};
      n_cmp++;
      if (outs !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", r, outs);
      end
    end
    srst = 1'b0;
    #1;
    n_cmp++;
    if (meas_ready !== 4'b0001) begin
      n_bad++; $display("FAIL reset_first_grant: got %b expected 0001", meas_ready);
    end
    step();
    meas_valid = '0;
    #1;
    n_cmp++;
    if ({core_enable, core_Zt, core_X_in, core_P_in} !== {1'b1, zt_tb[0], 36'd0, 72'd0}) begin
      n_bad++;
      $display("FAIL reset_regs_zero: got en=%b zt=%h x=%h p=%h expected 1/%h/0/0",
               core_enable, core_Zt, core_X_in, core_P_in, zt_tb[0]);
    end
    respond(1);
    n_cmp++;
    if ({res_valid, res_axis, res_X} !== {1'b1, 3'd0, 18'd7, zt_tb[0]}) begin
      n_bad++;
      $display("FAIL reset_first_result: got v=%b ax=%0d x=%h", res_valid, res_axis, res_X);
    end
    mx[0] = mdl_x(mx[0], zt_tb[0]); mp[0] = mdl_p(mp[0]);
    step(); #1;
  endtask

  task automatic test_single();
    logic err;
    init_write(3'd2, 3'd0, 18'd512, err);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL single_init_x00: got %b expected 0", err); end
    init_write(3'd2, 3'd2, 18'd512, err);
    zt_tb[2] = 18'd1024;
    meas_valid = 4'b0100;
    #1;
    n_cmp++;
    if (meas_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single_ready: got %b expected 0100", meas_ready);
    end
    step();
    meas_valid = '0;
    #1;
    n_cmp++;
    if ({core_enable, core_Zt, core_X_in, core_P_in} !==
        {1'b1, 18'd1024, 18'd0, 18'd512, 54'd0, 18'd512}) begin
      n_bad++;
      $display("FAIL single_issue: got en=%b zt=%h x=%h p=%h", core_enable, core_Zt,
               core_X_in, core_P_in);
    end
    step(); #1;
    n_cmp++;
    if ({core_enable, busy} !== 2'b01) begin
      n_bad++; $display("FAIL single_enable_pulse: got en=%b busy=%b expected 0/1", core_enable, busy);
    end
    repeat (4) step();
    core_valid = 1'b1;
    core_X_out = {18'd7, 18'd1536};
    core_P_out = {18'd4, 18'd3, 18'd2, 18'd256};
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_result: got 1 expected 0"); end
    step();
    core_valid = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, res_axis, res_X} !== {1'b1, 3'd2, 18'd7, 18'd1536}) begin
      n_bad++;
      $display("FAIL single_result_n7: got v=%b ax=%0d x=%h expected 1/2/%h",
               res_valid, res_axis, res_X, {18'd7, 18'd1536});
    end
    mx[2] = {18'd7, 18'd1536};
    mp[2] = {18'd4, 18'd3, 18'd2, 18'd256};
    step(); #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_back_idle: got v=%b busy=%b expected 0/0", res_valid, busy);
    end
    zt_tb[2] = 18'd0;
    meas_valid = 4'b0100;
    #1 step();
    meas_valid = '0;
    #1;
    n_cmp++;
    if ({core_X_in, core_P_in} !== {mx[2], mp[2]}) begin
      n_bad++;
      $display("FAIL single_writeback_regs: got x=%h p=%h expected x=%h p=%h",
               core_X_in, core_P_in, mx[2], mp[2]);
    end
    respond(5);
    mx[2] = mdl_x(mx[2], 18'd0); mp[2] = mdl_p(mp[2]);
    step(); #1;
  endtask

  task automatic test_round_robin();
    logic [NA-1:0] exp_ready;
    int ax;
    srst = 1'b1;
    step(); step();
    srst = 1'b0;
    clear_model();
    meas_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      ax = i % NA;
      exp_ready = 4'b0001 << ax;
      n_cmp++;
      if (meas_ready !== exp_ready) begin
        n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, meas_ready, exp_ready);
      end
      step(); #1;
      n_cmp++;
      if ({meas_ready, core_X_in} !== {4'b0000, mx[ax]}) begin
        n_bad++;
        $display("FAIL rr_issue[%0d]: got ready=%b x=%h expected 0000/%h", i, meas_ready,
                 core_X_in, mx[ax]);
      end
      respond(1);
      n_cmp++;
      if ({res_valid, res_axis, res_X} !== {1'b1, 3'(ax), mdl_x(mx[ax], zt_tb[ax])}) begin
        n_bad++;
        $display("FAIL rr_result[%0d]: got v=%b ax=%0d x=%h expected ax=%0d x=%h", i,
                 res_valid, res_axis, res_X, ax, mdl_x(mx[ax], zt_tb[ax]));
      end
      mx[ax] = mdl_x(mx[ax], zt_tb[ax]); mp[ax] = mdl_p(mp[ax]);
      step(); #1;
    end
    meas_valid = '0;
    #1;
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    meas_valid = 4'b0010;
    #1 step();
    meas_valid = '0;
    for (int c = 2; c < 200; c++) begin
      step();
      if (timeout_err === 1'b1) begin
        seen = c;
        break;
      end
    end
    n_cmp++;
    if (seen !== TO + 1) begin
      n_bad++; $display("FAIL timeout_cycle: got %0d expected %0d after handshake", seen, TO + 1);
    end
    step(); #1;
    n_cmp++;
    if ({timeout_err, busy} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_pulse: got err=%b busy=%b expected 0/0", timeout_err, busy);
    end
    core_valid = 1'b1;
    core_X_out = {18'h3FFFF, 18'h3FFFF};
    core_P_out = '1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_late_now: got 1 expected 0"); end
    step();
    core_valid = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_late_next: got v=%b busy=%b expected 0/0", res_valid, busy);
    end
    meas_valid = 4'b0010;
    #1 step();
    meas_valid = '0;
    #1;
    n_cmp++;
    if ({core_X_in, core_P_in} !== {mx[1], mp[1]}) begin
      n_bad++;
      $display("FAIL timeout_regs_kept: got x=%h p=%h expected x=%h p=%h",
               core_X_in, core_P_in, mx[1], mp[1]);
    end
    respond(1);
    mx[1] = mdl_x(mx[1], zt_tb[1]); mp[1] = mdl_p(mp[1]);
    step(); #1;
  endtask

  task automatic test_init_collision();
    logic err;
    logic [2*BW-1:0] xi;
    logic [4*BW-1:0] pi;
    meas_valid = 4'b1000;
    #1 step();
    meas_valid = '0;
    #1;
    xi = core_X_in; pi = core_P_in;
    step(); step();
    init_write(3'd3, 3'd0, 18'd999, err);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL collide_err: got %b expected 1", err); end
    init_write(3'd0, 3'd1, 18'd55, err);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL other_axis_init_err: got %b expected 0", err); end
    step();
    core_valid = 1'b1; core_X_out = mdl_x(xi, zt_tb[3]); core_P_out = mdl_p(pi);
    step();
    core_valid = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, res_axis, res_X} !== {1'b1, 3'd3, mdl_x(mx[3], zt_tb[3])}) begin
      n_bad++;
      $display("FAIL collide_result: got v=%b ax=%0d x=%h expected 3/%h", res_valid,
               res_axis, res_X, mdl_x(mx[3], zt_tb[3]));
    end
    mx[3] = mdl_x(mx[3], zt_tb[3]); mp[3] = mdl_p(mp[3]);
    mx[0][2*BW-1:BW] = 18'd55;
    step();
    for (int a = 3; a >= 0; a -= 3) begin
      meas_valid = 4'b0001 << a;
      #1 step();
      meas_valid = '0;
      #1;
      n_cmp++;
      if ({core_X_in, core_P_in} !== {mx[a], mp[a]}) begin
        n_bad++;
        $display("FAIL collide_regs_axis%0d: got x=%h p=%h expected x=%h p=%h", a,
                 core_X_in, core_P_in, mx[a], mp[a]);
      end
      respond(1);
      mx[a] = mdl_x(mx[a], zt_tb[a]); mp[a] = mdl_p(mp[a]);
      step();
    end
    #1;
    init_write(3'd5, 3'd0, 18'd1, err);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bad_axis_err: got %b expected 1", err); end
    init_write(3'd1, 3'd6, 18'd1, err);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bad_sel_err: got %b expected 1", err); end
  endtask

  task automatic test_init_bypass();
    logic [4*BW-1:0] exp_p;
    exp_p = {mp[1][4*BW-1:BW], 18'd77};
    init_en = 1'b1; init_axis = 3'd1; init_sel = 3'd2; init_data = 18'd77;
    meas_valid = 4'b0010;
    #1;
    n_cmp++;
    if ({init_err, meas_ready} !== {1'b0, 4'b0010}) begin
      n_bad++; $display("FAIL bypass_accept: got err=%b ready=%b expected 0/0010", init_err, meas_ready);
    end
    step();
    init_en = 1'b0; meas_valid = '0;
    #1;
    n_cmp++;
    if (core_P_in !== exp_p) begin
      n_bad++; $display("FAIL bypass_dispatch: got %h expected %h", core_P_in, exp_p);
    end
    respond(1);
    mx[1] = mdl_x(mx[1], zt_tb[1]); mp[1] = mdl_p(exp_p);
    step(); #1;
  endtask

  task automatic test_reset_in_wait();
    meas_valid = 4'b0001;
    #1 step();
    meas_valid = '0;
    step(); step();
    srst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, core_enable, res_valid} !== 3'b000) begin
      n_bad++; $display("FAIL srst_outputs: got busy=%b en=%b v=%b expected 0", busy, core_enable, res_valid);
    end
    step();
    srst = 1'b0;
    clear_model();
    core_valid = 1'b1; core_X_out = {18'd3, 18'd3}; core_P_out = '1;
    #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL srst_drop_now: got v=%b busy=%b expected 0/0", res_valid, busy);
    end
    step();
    core_valid = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL srst_drop_next: got v=%b busy=%b expected 0/0", res_valid, busy);
    end
    meas_valid = 4'b0010;
    #1 step();
    meas_valid = '0;
    #1;
    n_cmp++;
    if ({core_X_in, core_P_in} !== {36'd0, 72'd0}) begin
      n_bad++;
      $display("FAIL srst_regs_zero: got x=%h p=%h expected 0", core_X_in, core_P_in);
    end
    respond(1);
    n_cmp++;
    if ({res_valid, res_axis, res_X} !== {1'b1, 3'd1, 18'd7, zt_tb[1]}) begin
      n_bad++; $display("FAIL srst_after_result: got v=%b ax=%0d x=%h", res_valid, res_axis, res_X);
    end
    step(); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst = 1'b1;
    meas_valid = 4'b1111;
    init_en = 1'b0; init_axis = '0; init_sel = '0; init_data = '0;
    core_valid = 1'b0; core_X_out = '0; core_P_out = '0;
    for (int a = 0; a < NA; a++) zt_tb[a] = 18'(16 * (a + 1));
    clear_model();

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_init_collision();
    test_init_bypass();
    test_reset_in_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
